// File: rtl/vga_write_arbiter.sv
`default_nettype none
// vga_write_arbiter: round-robin ownership of the single VGA write port.
// The owner's pixel strobes reach the adapter through one register stage.
module vga_write_arbiter #(
  parameter int N  = 4,
  parameter int IW = 3
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  input  logic [8*N-1:0] in_x,
  input  logic [7*N-1:0] in_y,
  input  logic [3*N-1:0] in_colour,
  input  logic [N-1:0]   in_write,
  output logic [7:0]     vga_x,
  output logic [6:0]     vga_y,
  output logic [2:0]     vga_colour,
  output logic           vga_write,
  output logic           busy,
  output logic [IW-1:0]  owner
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] owner_next;
  logic [IW-1:0] pick;
  logic [N-1:0]  gnt_next;
  logic          vga_write_next;
  logic          load_pixel;

  logic          own_req;
  logic          own_wr;
  logic [7:0]    own_x;
  logic [6:0]    own_y;
  logic [2:0]    own_colour;

  always_comb begin : owner_mux
    own_req    = 1'b0;
    own_wr     = 1'b0;
    own_x      = '0;
    own_y      = '0;
    own_colour = '0;
    for (int j = 0; j < N; j++) begin
      if (owner == IW'(j)) begin
        own_req    = req[j];
        own_wr     = in_write[j];
        own_x      = in_x[8*j +: 8];
        own_y      = in_y[7*j +: 7];
        own_colour = in_colour[3*j +: 3];
      end
    end
  end

  // Lowest requester above owner wins; otherwise wrap to the lowest at or below owner.
  always_comb begin : rr_pick
    pick = owner;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j] && (IW'(j) <= owner)) pick = IW'(j);
    end
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j] && (IW'(j) > owner)) pick = IW'(j);
    end
  end

  always_comb begin : fsm_next
    state_next     = state;
    owner_next     = owner;
    gnt_next       = gnt;
    vga_write_next = 1'b0;
    load_pixel     = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_next = GRANT;
          owner_next = pick;
          for (int j = 0; j < N; j++) begin
            gnt_next[j] = (IW'(j) == pick);
          end
        end
      end
      GRANT: begin
        vga_write_next = own_wr & own_req;
        load_pixel     = own_wr;
        if (!own_req) begin
          state_next = IDLE;
          gnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= '0;
      owner      <= IW'(N - 1);
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_write  <= 1'b0;
    end else begin
      state     <= state_next;
      gnt       <= gnt_next;
      owner     <= owner_next;
      vga_write <= vga_write_next;
      if (load_pixel) begin
        vga_x      <= own_x;
        vga_y      <= own_y;
        vga_colour <= own_colour;
      end
    end
  end

  assign busy = (state == GRANT);

endmodule
`default_nettype wire

// File: tb/tb_vga_write_arbiter.sv
`default_nettype none
// tb_vga_write_arbiter: directed test-plan scenarios plus randomized traffic,
// every cycle compared against a behavioural arbiter model.
module tb_vga_write_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [8*N-1:0] in_x;
  logic [7*N-1:0] in_y;
  logic [3*N-1:0] in_colour;
  logic [N-1:0]   in_write;
  logic [7:0]     vga_x;
  logic [6:0]     vga_y;
  logic [2:0]     vga_colour;
  logic           vga_write;
  logic           busy;
  logic [IW-1:0]  owner;

  vga_write_arbiter #(.N(N), .IW(IW)) dut (
    .clock(clock), .reset(reset), .req(req), .gnt(gnt),
    .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .in_write(in_write),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_write(vga_write), .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit         m_busy;
  int         m_owner;
  logic [N-1:0] m_gnt;
  logic [7:0] m_x;
  logic [6:0] m_y;
  logic [2:0] m_c;
  bit         m_wr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_edge();
    if (reset) begin
      m_busy = 0; m_owner = N - 1; m_gnt = '0;
      m_x = '0; m_y = '0; m_c = '0; m_wr = 0;
    end else if (!m_busy) begin
      m_wr = 0;
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_owner + k) % N;
        if (req[i]) begin
          m_owner = i;
          m_gnt   = N'(1) << i;
          m_busy  = 1;
          break;
        end
      end
    end else begin
      m_wr = in_write[m_owner] && req[m_owner];
      if (in_write[m_owner]) begin
        m_x = in_x[8*m_owner +: 8];
        m_y = in_y[7*m_owner +: 7];
        m_c = in_colour[3*m_owner +: 3];
      end
      if (!req[m_owner]) begin
        m_busy = 0;
        m_gnt  = '0;
      end
    end
  endfunction

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check("gnt",        32'(gnt),        32'(m_gnt));
    check("owner",      32'(owner),      32'(m_owner));
    check("busy",       32'(busy),       32'(m_busy));
    check("vga_write",  32'(vga_write),  32'(m_wr));
    check("vga_x",      32'(vga_x),      32'(m_x));
    check("vga_y",      32'(vga_y),      32'(m_y));
    check("vga_colour", 32'(vga_colour), 32'(m_c));
  endtask

  task automatic set_pixel(input int i, input int x, input int y, input int c);
    in_x[8*i +: 8]      = 8'(x);
    in_y[7*i +: 7]      = 7'(y);
    in_colour[3*i +: 3] = 3'(c);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; in_write = '0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int grants[$];
    int idle_run;
    int wcnt;
    bit prev_busy;

    reset = 1'b1; req = '0; in_write = '0;
    in_x = '0; in_y = '0; in_colour = '0;
    m_busy = 0; m_owner = N - 1; m_gnt = '0; m_x = '0; m_y = '0; m_c = '0; m_wr = 0;

    // Reset state and first grant / first pixel
    step();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_owner", 32'(owner), 32'd3);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0; req = 4'b0001;
    step();
    check("first_gnt", 32'(gnt), 32'b0001);
    check("first_owner", 32'(owner), 32'd0);
    set_pixel(0, 10, 20, 5); in_write = 4'b0001;
    step();
    check("first_px", {vga_write, 5'd0, vga_colour, 1'b0, vga_y, vga_x}, {1'b1, 5'd0, 3'd5, 1'b0, 7'd20, 8'd10});
    in_write = '0; req = '0;
    step(); step();

    // All four requesting: round-robin order with one dead cycle between owners
    do_reset();
    req = 4'b1111; wcnt = 0; prev_busy = 0; idle_run = 0;
    for (int cyc = 0; cyc < 80 && grants.size() < 5; cyc++) begin
      if (m_busy && wcnt < 4) begin
        in_write = N'(1) << m_owner;
        set_pixel(m_owner, $urandom, $urandom, $urandom);
        wcnt++;
      end else if (m_busy) begin
        in_write = '0;
        req[m_owner] = 1'b0;
      end else begin
        in_write = '0; req = 4'b1111; wcnt = 0;
      end
      step();
      if (m_busy && !prev_busy) begin
        grants.push_back(int'(owner));
        if (grants.size() > 1) check("dead_cycles", 32'(idle_run), 32'd1);
        idle_run = 0;
      end else if (!m_busy) idle_run++;
      prev_busy = m_busy;
    end
    check("rr_count", 32'(grants.size()), 32'd5);
    for (int g = 0; g < grants.size(); g++) check("rr_order", 32'(grants[g]), 32'(g % N));
    req = '0; in_write = '0;
    step(); step();

    // Owner 2 streams while requester 1 strobes (99,99,7) every cycle
    do_reset();
    req = 4'b0100;
    step();
    req = 4'b0110; set_pixel(1, 99, 99, 7);
    for (int k = 0; k < 16; k++) begin
      in_write = 4'b0110;
      set_pixel(2, k + 1, k + 2, k % 8);
      step();
      check("stream_gnt", 32'(gnt), 32'b0100);
      check("stream_px", {vga_write, vga_colour, vga_y, vga_x}, {1'b1, 3'(k % 8), 7'(k + 2), 8'(k + 1)});
    end
    // Drop request together with a strobe: pixel dropped, grant cleared
    req = 4'b0010; set_pixel(2, 200, 100, 3);
    step();
    check("drop_gnt", 32'(gnt), 32'h0);
    check("drop_wr", 32'(vga_write), 32'h0);
    step();
    check("next_gnt", 32'(gnt), 32'b0010);
    req = '0; in_write = '0;
    step(); step();

    // Wrap-around from owner 3
    do_reset();
    req = 4'b1000;
    step();
    req = '0;
    step();
    req = 4'b1001;
    step();
    check("wrap_gnt0", 32'(gnt), 32'b0001);
    req = 4'b1000;
    step(); step();
    check("wrap_gnt3", 32'(gnt), 32'b1000);

    // Reset mid-stream
    in_write = 4'b1000; set_pixel(3, 55, 66, 6);
    step(); step();
    check("pre_rst_wr", 32'(vga_write), 32'h1);
    reset = 1'b1;
    step();
    check("mid_rst", {gnt, vga_write, busy, vga_x, vga_y, vga_colour}, 32'h0);
    reset = 1'b0; req = 4'b0010; in_write = '0;
    step();
    check("post_rst_gnt", 32'(gnt), 32'b0010);
    req = '0;
    step(); step();

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (m_busy && m_owner == i) req[i] = ($urandom % 6) != 0;
        else if (req[i])            req[i] = ($urandom % 8) != 0;
        else                        req[i] = ($urandom % 4) == 0;
      end
      in_write  = N'($urandom);
      in_x      = 32'($urandom);
      in_y      = 28'($urandom);
      in_colour = 12'($urandom);
      reset     = ($urandom % 200) == 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
